rl_modexp_param: RTL and testbench
==================================

// Module: rl_modexp_param
// PURPOSE
//  Parametrised right-to-left binary modular exponentiator, r = base^exp mod modulus; next generation of the 32-bit RSA core.
//  Generalises operand and exponent widths; adds busy/done handshake, error flag, input reduction of base >= modulus.
//  Sits under the RSA top; encrypt and decrypt use the same block with different exp.
// PARAMETERS
//  WIDTH      32     operand width of base, modulus, r
//  EXP_WIDTH  WIDTH  exponent width; K = number of exponent bits scanned
// PORTS
//  clk       in   1          clock, rising edge
//  rstn      in   1          async active-low reset
//  md_start  in   1          start pulse; sampled only when idle
//  base      in   WIDTH      message/cipher; any value, reduced internally
//  exp       in   EXP_WIDTH  exponent
//  modulus   in   WIDTH      modulus m
//  r         out  WIDTH      result; held until next completion
//  busy      out  1          operation in progress
//  done      out  1          one-cycle completion pulse
//  err       out  1          m==0 on last op; valid with done, held until next start
// BEHAVIOUR
//  Reset: r=0, busy=0, done=0, err=0, FSM=IDLE, multipliers idle. Reset mid-op aborts; no done pulse.
//  Start: md_start=1 in IDLE latches base/exp/modulus; busy=1 from next cycle; inputs don't-care after.
//  md_start while busy: ignored, no effect on running op.
//  FSM: IDLE -> RED -> ISSUE <-> WAIT -> FIN -> IDLE.
//   RED: B = base*1 mod m (one mod_mul pass), result R = 1.
//   ISSUE: start square (B*B) and, if exp_sh[0]=1, multiply (R*B) on two mod_mul instances in parallel.
//   WAIT: on mul done, update B (and R if bit set), exp_sh >>= 1, count++; more bits -> ISSUE, else FIN.
//   FIN: r <= R, done=1 for one cycle, busy=0 same cycle, -> IDLE.
//  Each mod_mul phase (RED or one exp bit): exactly WIDTH+2 cycles incl. ISSUE.
//  Latency: done rises N = (1+K)*(WIDTH+2)+1 cycles after md_start sampling edge. Default K=EXP_WIDTH; WIDTH=32 -> 1123.
//  Special cases, skip RED/loop; done 2 cycles after start:
//   m==0 -> r=0, err=1.
//   m==1 -> r=0, err=0.
//  exp==0 with m>1: r=1 after full K iterations; no short cut unless macro enabled.
//  Arithmetic: mod_mul is MSB-first interleaved (Blakley).
//   Per bit: P = 2P + a_i*b, then up to two conditional subtractions of m.
//   P held in WIDTH+2 bits; requires b < m and m >= 2; a may be any WIDTH-bit value.
//  Outputs r/err change only in FIN (or special-case finish).
// CONFIGURATION
//  RL_MODEXP_EARLY_EXIT_EN defined:
//   loop ends once remaining exp_sh == 0; K = index of highest set bit + 1.
//   exp==0 -> K=0: done at (WIDTH+2)+1 cycles, r=1 (m>1).
//  Not defined: K = EXP_WIDTH always; constant-time latency, side-channel safe default.
// STRUCTURE
//  Package rsa_pkg: FSM state encoding (IDLE,RED,ISSUE,WAIT,FIN), MM_LAT = WIDTH+2, default width constants.
//  Sub-module mod_mul_interleaved #(WIDTH): start/a/b/m in; p/done out; done exactly WIDTH+1 cycles after start.
//   Two instances: square, multiply.
//  Top holds B, R, exp_sh, bit counter, latched modulus, FSM.
// TESTING
//  Round trip: base=52525252, exp=17, m=128255609 -> r=C, done at 1123 cycles.
//   Then base=C, exp=75431153 -> r=52525252.
//  Small vector: base=4, exp=13, m=497 -> r=445.
//   Also base=0xFFFFFFFF, exp=1, m=1000 -> r=295 (input reduction).
//  Edges:
//   m=0 -> err=1, r=0, done 2 cycles after start.
//   m=1 -> r=0, err=0.
//   exp=0, m=497 -> r=1; latency 1123 (34+1 with RL_MODEXP_EARLY_EXIT_EN).
//  Handshake: md_start pulsed again at cycle 100 of an op -> ignored, result/latency unchanged.
//   busy=0 on done cycle; back-to-back start on next cycle accepted.
//  Reset at cycle 500 of an op: r=0, busy=0, no done.
//   Then fresh start base=4, exp=13, m=497 -> 445.
//  Param sweep WIDTH=16, EXP_WIDTH=16: base=1234, exp=65535, m=65521 vs reference model; latency 17*18+1=307.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath:
// FSM state encoding, default widths and mod_mul phase length.
package rsa_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_MM_LAT = DEF_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RED,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    // Cycles one mod_mul phase occupies, counting the cycle that issues it.
    function automatic int mm_lat(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mod_mul_interleaved.sv
// MSB-first interleaved (Blakley) modular multiplier: p = a*b mod m.
// Requires b < m and m >= 2; done pulses exactly WIDTH+1 cycles after start.
module mod_mul_interleaved
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int PW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [PW-1:0]    p_q, b_q, m_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;
    logic [PW-1:0]    t0_d, t1_d, p_d;

    // 2P + b stays below 3m < 2^(WIDTH+2), so two trial subtractions suffice.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        t0_d = (p_q << 1) + (a_q[WIDTH-1] ? b_q : '0);
        t1_d = (t0_d >= m_q) ? t0_d - m_q : t0_d;
        p_d  = (t1_d >= m_q) ? t1_d - m_q : t1_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q    <= '0;
            p_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            if (start) begin
                a_q   <= a;
                b_q   <= {2'b00, b};
                m_q   <= {2'b00, m};
                p_q   <= '0;
                cnt_q <= CW'(WIDTH);
                run_q <= 1'b1;
            end else if (run_q) begin
                p_q   <= p_d;
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign p    = p_q[WIDTH-1:0];
    assign done = done_q;

endmodule

// File: rtl/rl_modexp_param.sv
// Right-to-left binary modular exponentiator r = base^exp mod modulus.
// Define RL_MODEXP_EARLY_EXIT_EN to stop scanning once the remaining exponent is zero.
module rl_modexp_param
    import rsa_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 md_start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     r,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(EXP_WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t               state_q;
    logic [WIDTH-1:0]     b_q, acc_q, m_q, r_q;
    logic [EXP_WIDTH-1:0] exp_sh_q;
    logic [CW-1:0]        cnt_q;
    logic                 mm_run_q, err_acc_q, busy_q, done_q, err_q;

    logic                 mm_ok, last_bit, red_skip;
    logic                 sq_start, mul_start, sq_done, mul_done;
    logic [WIDTH-1:0]     sq_b, sq_p, mul_p;

    assign mm_ok = m_q > ONE;

    always_comb begin
`ifdef RL_MODEXP_EARLY_EXIT_EN
        last_bit = (exp_sh_q >> 1) == '0;
        red_skip = exp_sh_q == '0;
`else
        last_bit = cnt_q == CW'(EXP_WIDTH - 1);
        red_skip = 1'b0;
`endif
    end

    // The reduction pass reuses the squarer as base*1 mod m.
    assign sq_start  = (state_q == S_RED && !mm_run_q && mm_ok) || state_q == S_ISSUE;
    assign mul_start = state_q == S_ISSUE && exp_sh_q[0];
    assign sq_b      = (state_q == S_RED) ? ONE : b_q;

    mod_mul_interleaved #(.WIDTH(WIDTH)) u_square (
        .clk(clk), .rstn(rstn), .start(sq_start),
        .a(b_q), .b(sq_b), .m(m_q), .p(sq_p), .done(sq_done)
    );

    mod_mul_interleaved #(.WIDTH(WIDTH)) u_multiply (
        .clk(clk), .rstn(rstn), .start(mul_start),
        .a(acc_q), .b(b_q), .m(m_q), .p(mul_p), .done(mul_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            b_q       <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            r_q       <= '0;
            exp_sh_q  <= '0;
            cnt_q     <= '0;
            mm_run_q  <= 1'b0;
            err_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        b_q       <= base;
                        exp_sh_q  <= exp;
                        m_q       <= modulus;
                        acc_q     <= ONE;
                        cnt_q     <= '0;
                        mm_run_q  <= 1'b0;
                        err_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RED;
                    end
                end
                S_RED: begin
                    if (!mm_run_q) begin
                        if (!mm_ok) begin
                            // m of 0 or 1 has no meaningful residue; finish with r = 0.
                            acc_q     <= '0;
                            err_acc_q <= m_q == '0;
                            state_q   <= S_FIN;
                        end else begin
                            mm_run_q <= 1'b1;
                        end
                    end else if (sq_done) begin
                        mm_run_q <= 1'b0;
                        b_q      <= sq_p;
                        state_q  <= red_skip ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (sq_done) begin
                        b_q      <= sq_p;
                        exp_sh_q <= exp_sh_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        state_q  <= last_bit ? S_FIN : S_ISSUE;
                    end
                    if (mul_done) acc_q <= mul_p;
                end
                S_FIN: begin
                    r_q     <= acc_q;
                    err_q   <= err_acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rl_modexp_param.sv
// Self-checking bench for rl_modexp_param: cycle-by-cycle model compare plus directed vectors.
module tb_rl_modexp_param;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        md_start = 1'b0;
    logic [31:0] base_s = '0, exp_s = '0, mod_s = '0;
    logic [31:0] r_o;
    logic        busy_o, done_o, err_o;

    logic        md16 = 1'b0;
    logic [15:0] base16 = '0, exp16 = '0, mod16 = '0;
    logic [15:0] r16;
    logic        busy16, done16, err16;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rl_modexp_param dut32 (
        .clk(clk), .rstn(rstn), .md_start(md_start), .base(base_s), .exp(exp_s),
        .modulus(mod_s), .r(r_o), .busy(busy_o), .done(done_o), .err(err_o)
    );

    rl_modexp_param #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
        .clk(clk), .rstn(rstn), .md_start(md16), .base(base16), .exp(exp16),
        .modulus(mod16), .r(r16), .busy(busy16), .done(done16), .err(err16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Left-to-right square-and-multiply over k exponent bits, base reduced first.
    function automatic logic [31:0] mexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m, input int k);
        longint unsigned acc, bb, mm, ee;
        if (m <= 32'd1) return 32'd0;
        mm  = 64'(m);
        ee  = 64'(e);
        bb  = 64'(b) % mm;
        acc = 1;
        for (int i = k - 1; i >= 0; i--) begin
            acc = (acc * acc) % mm;
            if (((ee >> i) & 64'd1) != 0) acc = (acc * bb) % mm;
        end
        return 32'(acc);
    endfunction

    function automatic int lat_of(input logic [31:0] e, input logic [31:0] m, input int w, input int ew);
        int k;
        if (m <= 32'd1) return 2;
        k = ew;
`ifdef RL_MODEXP_EARLY_EXIT_EN
        k = 0;
        for (int i = 0; i < ew; i++) if (e[i]) k = i + 1;
`endif
        return (1 + k) * (w + 2) + 1;
    endfunction

    // Transaction-level model of the 32-bit instance.
    logic        m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, m_pend_err = 1'b0;
    logic [31:0] m_r = '0, m_pend_r = '0;
    int          m_cnt = 0, m_lat = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_r      <= '0;
            m_err    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_cnt + 1 == m_lat) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_r      <= m_pend_r;
                    m_err    <= m_pend_err;
                end
                m_cnt <= m_cnt + 1;
            end else if (md_start) begin
                m_active   <= 1'b1;
                m_cnt      <= 0;
                m_pend_r   <= mexp(base_s, exp_s, mod_s, 32);
                m_pend_err <= mod_s == 32'd0;
                m_lat      <= lat_of(exp_s, mod_s, 32, 32);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn)
            check("cycle busy/done/err/r", {29'd0, busy_o, done_o, err_o, r_o},
                  {29'd0, m_active, m_done, m_err, m_r});
    end

    task automatic issue(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                         input bit immediate);
        if (!immediate) @(negedge clk);
        base_s = b; exp_s = e; mod_s = m; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        base_s = $urandom; exp_s = $urandom; mod_s = $urandom;
    endtask

    // Returns at the negedge where done is seen; lat counts edges after the sampling edge.
    task automatic wait_done(input int poke_at, output int lat);
        int cnt = 0;
        lat = -1;
        while (cnt < 4000) begin
            if (done_o) begin
                lat = cnt;
                break;
            end
            md_start = (cnt == poke_at);
            @(negedge clk);
            cnt++;
        end
        md_start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] m, input logic [31:0] exp_r, input logic exp_err,
                          input int exp_lat, input int poke_at, input bit immediate);
        int lat;
        issue(b, e, m, immediate);
        wait_done(poke_at, lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " r"}, 64'(r_o), 64'(exp_r));
        check({name, " err"}, 64'(err_o), 64'(exp_err));
        check({name, " busy on done"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [31:0] c;
        int          lat;
        bit          saw_done;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset r", 64'(r_o), 64'd0);
        check("reset busy/done/err", {61'd0, busy_o, done_o, err_o}, 64'd0);
        check("reset w16 r/busy", {47'd0, busy16, r16}, 64'd0);

        run_op("small", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, lat_of(32'd13, 32'd497, 32, 32), -1, 1'b0);
        run_op("reduce", 32'hFFFF_FFFF, 32'd1, 32'd1000, 32'd295, 1'b0, lat_of(32'd1, 32'd1000, 32, 32), -1, 1'b0);

        c = mexp(32'd52525252, 32'd17, 32'd128255609, 32);
        run_op("rt enc", 32'd52525252, 32'd17, 32'd128255609, c, 1'b0,
               lat_of(32'd17, 32'd128255609, 32, 32), -1, 1'b0);
        run_op("rt dec", c, 32'd75431153, 32'd128255609, 32'd52525252, 1'b0,
               lat_of(32'd75431153, 32'd128255609, 32, 32), -1, 1'b0);

        run_op("m0", 32'd7, 32'd5, 32'd0, 32'd0, 1'b1, 2, -1, 1'b0);
        repeat (5) @(negedge clk);
        check("m0 err held", 64'(err_o), 64'd1);
        run_op("m1", 32'd7, 32'd5, 32'd1, 32'd0, 1'b0, 2, -1, 1'b0);
        run_op("exp0", 32'd9, 32'd0, 32'd497, 32'd1, 1'b0, lat_of(32'd0, 32'd497, 32, 32), -1, 1'b0);

        run_op("restart ignored", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0,
               lat_of(32'd13, 32'd497, 32, 32), 100, 1'b0);
        run_op("back2back", 32'hFFFF_FFFF, 32'd1, 32'd1000, 32'd295, 1'b0,
               lat_of(32'd1, 32'd1000, 32, 32), -1, 1'b1);

        issue(32'd4, 32'd13, 32'd497, 1'b0);
        repeat (499) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort r", 64'(r_o), 64'd0);
        check("abort busy/done/err", {61'd0, busy_o, done_o, err_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        check("abort no done", 64'(saw_done), 64'd0);
        run_op("after abort", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, lat_of(32'd13, 32'd497, 32, 32), -1, 1'b0);

        @(negedge clk);
        base16 = 16'd1234; exp16 = 16'd65535; mod16 = 16'd65521; md16 = 1'b1;
        @(negedge clk);
        md16 = 1'b0; base16 = '0; exp16 = '0; mod16 = '0;
        lat = -1;
        for (int i = 0; i < 1000; i++) begin
            if (done16) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("w16 latency", 64'(lat), 64'd307);
        check("w16 r", 64'(r16), 64'(mexp(32'd1234, 32'd65535, 32'd65521, 16)));
        check("w16 err/busy", {62'd0, err16, busy16}, 64'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
